// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one pipelined multiplier between NUM_REQ requesters.
//
// A round-robin arbiter grants at most one requester per cycle. Granted
// operands are registered onto mult_a/mult_b. A tag pipeline of {vld, id}
// tracks each operation, and the product is returned to the requester that
// issued it.
//
// Ports
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   en          issue enable; low blocks new grants while in-flight work drains
//   req_valid   per-requester request
//   req_a/b     flattened operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready   one-hot combinational grant
//   mult_a/b    registered operands to the multiplier
//   mult_y      product from the multiplier, MULT_LAT edges after mult_a/b
//   rsp_valid   one-hot single-cycle response strobe
//   rsp_y       registered product, meaningful while rsp_valid != 0
//   inflight    accepted operations not yet responded
//
// Handshake: requester i is accepted on a rising edge where
// req_valid[i] && req_ready[i]. Its operands are sampled only on that edge.
// req_ready never depends on anything but req_valid, en and the
// round-robin pointer, so the path is combinational but loop-free.
module mult_arbiter #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2,
  parameter int IDW      = $clog2(NUM_REQ),
  localparam int CW      = $clog2(MULT_LAT + 2)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           mult_a,
  output logic [WIDTH-1:0]           mult_b,
  input  logic [2*WIDTH-1:0]         mult_y,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]         rsp_y,
  output logic [CW-1:0]              inflight
);

  logic [IDW-1:0]              rr_ptr;
  logic [IDW-1:0]              grant_id;
  logic                        accept;
  logic [IDW-1:0]              next_ptr;
  logic                        done;

  // Tag stage 0 is loaded on the accept edge. The product lands on mult_y
  // after MULT_LAT further edges, so the final stage (index MULT_LAT)
  // lines up with a valid mult_y and is consumed on the edge after that.
  logic [MULT_LAT:0]           tag_vld;
  logic [MULT_LAT:0][IDW-1:0]  tag_id;

  // Round-robin scan starting at rr_ptr; the first valid requester wins.
  always_comb begin
    int idx;
    idx      = 0;
    accept   = 1'b0;
    grant_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (en && !accept && req_valid[idx[IDW-1:0]]) begin
        accept   = 1'b1;
        grant_id = idx[IDW-1:0];
      end
    end
  end

  assign req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  assign next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
  assign done      = tag_vld[MULT_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_a    <= '0;
      mult_b    <= '0;
      rr_ptr    <= '0;
      tag_vld   <= '0;
      tag_id    <= '0;
      rsp_valid <= '0;
      rsp_y     <= '0;
      inflight  <= '0;
    end else begin
      // Tags shift every edge; the multiplier has no backpressure.
      tag_vld <= {tag_vld[MULT_LAT-1:0], accept};
      tag_id  <= {tag_id[MULT_LAT-1:0], grant_id};

      if (accept) begin
        mult_a <= req_a[int'(grant_id)*WIDTH +: WIDTH];
        mult_b <= req_b[int'(grant_id)*WIDTH +: WIDTH];
        rr_ptr <= next_ptr;
      end

      rsp_valid <= done ? (NUM_REQ'(1) << tag_id[MULT_LAT]) : '0;
      if (done) begin
        rsp_y <= mult_y;
      end

      case ({accept, done})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter (WIDTH=32, NUM_REQ=4, MULT_LAT=2).
// The bench supplies a two-stage multiplier model on mult_y.
module tb_mult_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int ML = 2;
  localparam int CW = $clog2(ML + 2);

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic [N-1:0]      req_ready;
  logic [W-1:0]      mult_a;
  logic [W-1:0]      mult_b;
  logic [2*W-1:0]    mult_y;
  logic [N-1:0]      rsp_valid;
  logic [2*W-1:0]    rsp_y;
  logic [CW-1:0]     inflight;

  logic [2*W-1:0]    m_p1;

  int n_vec;
  int n_err;
  int n_rsp;

  int          exp_inf3 [8] = '{1, 2, 3, 3, 2, 1, 0, 0};
  logic [63:0] exp_y3   [4] = '{64'd7000, 64'd14000, 64'd21000, 64'd28000};
  int          exp_inf5 [5] = '{2, 1, 0, 0, 0};
  logic [3:0]  exp_rv5  [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b0000};
  logic [63:0] exp_y5   [5] = '{64'd0, 64'd6, 64'd9, 64'd0, 64'd0};

  mult_arbiter #(.WIDTH(W), .NUM_REQ(N), .MULT_LAT(ML)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_y    (mult_y),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .inflight  (inflight)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage multiplier model: operands set at edge T, product on mult_y after T+2.
  always @(posedge clk) begin
    m_p1   <= {32'b0, mult_a} * {32'b0, mult_b};
    mult_y <= m_p1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_rsp = 0;
    rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_mult_a",    64'(mult_a),    64'd0);
    chk("rst_mult_b",    64'(mult_b),    64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_y",     rsp_y,          64'd0);
    chk("rst_inflight",  64'(inflight),  64'd0);
    chk("rst_ready",     64'(req_ready), 64'd0);
    rst_n = 1'b1; en = 1'b1;
    #1 chk("idle_ready", 64'(req_ready), 64'd0);
    tick();
    chk("idle_inflight", 64'(inflight), 64'd0);

    // Single requester 1: 10*20
    set_op(1, 32'd10, 32'd20);
    req_valid = 4'b0010;
    #1 chk("single_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("single_mult_a", 64'(mult_a),    64'd10);
    chk("single_mult_b", 64'(mult_b),    64'd20);
    chk("single_inf1",   64'(inflight),  64'd1);
    chk("single_rsp1",   64'(rsp_valid), 64'd0);
    tick();
    chk("single_inf2",   64'(inflight),  64'd1);
    chk("single_rsp2",   64'(rsp_valid), 64'd0);
    tick();
    chk("single_inf3",   64'(inflight),  64'd1);
    chk("single_rsp3",   64'(rsp_valid), 64'd0);
    tick();
    chk("single_rsp_v",  64'(rsp_valid), 64'b0010);
    chk("single_rsp_y",  rsp_y,          64'd200);
    chk("single_inf4",   64'(inflight),  64'd0);
    tick();
    chk("single_strobe", 64'(rsp_valid), 64'd0);

    // Asynchronous reset between edges clears registered outputs at once
    #2 rst_n = 1'b0;
    #1;
    chk("async_mult_a", 64'(mult_a), 64'd0);
    chk("async_mult_b", 64'(mult_b), 64'd0);
    chk("async_rsp_y",  rsp_y,       64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four continuously valid: (i+1)*1000 * 7
    for (int i = 0; i < N; i++) set_op(i, 32'((i + 1) * 1000), 32'd7);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c < 4) ? 4'hF : 4'h0;
      #1;
      if (c < 4) chk("rr_grant", 64'(req_ready), 64'(4'b0001 << c));
      tick();
      chk("rr_inflight", 64'(inflight), 64'(exp_inf3[c]));
      if (c >= 3 && c <= 6) begin
        chk("rr_rsp_v", 64'(rsp_valid), 64'(4'b0001 << (c - 3)));
        chk("rr_rsp_y", rsp_y, exp_y3[c-3]);
      end else begin
        chk("rr_rsp_idle", 64'(rsp_valid), 64'd0);
      end
    end

    // Boundary operands, back-to-back: req 2 then req 3
    set_op(2, 32'hFFFF_FFFF, 32'd2);
    set_op(3, 32'd12345, 32'd0);
    req_valid = 4'b1100;
    #1 chk("bnd_grant2", 64'(req_ready), 64'b0100);
    tick();
    req_valid = 4'b1000;
    #1 chk("bnd_grant3", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    chk("bnd_rsp_e1", 64'(rsp_valid), 64'd0);
    tick();
    chk("bnd_rsp_e2", 64'(rsp_valid), 64'd0);
    tick();
    chk("bnd_rsp2_v", 64'(rsp_valid), 64'b0100);
    chk("bnd_rsp2_y", rsp_y, 64'h1_FFFF_FFFE);
    tick();
    chk("bnd_rsp3_v", 64'(rsp_valid), 64'b1000);
    chk("bnd_rsp3_y", rsp_y, 64'd0);
    tick();
    chk("bnd_done_v",   64'(rsp_valid), 64'd0);
    chk("bnd_done_inf", 64'(inflight),  64'd0);

    // en drop after two accepts
    for (int i = 0; i < N; i++) set_op(i, 32'(i + 2), 32'd3);
    req_valid = 4'hF;
    #1 chk("en_grant0", 64'(req_ready), 64'b0001);
    tick();
    chk("en_grant1", 64'(req_ready), 64'b0010);
    tick();
    en = 1'b0;
    #1 chk("en_off_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_off_ready_k", 64'(req_ready), 64'd0);
      chk("en_inflight",    64'(inflight),  64'(exp_inf5[k]));
      chk("en_rsp_v",       64'(rsp_valid), 64'(exp_rv5[k]));
      if (rsp_valid != 0) begin
        n_rsp++;
        chk("en_rsp_y", rsp_y, exp_y5[k]);
      end
    end
    chk("en_rsp_count", 64'(n_rsp), 64'd2);
    en = 1'b1;
    #1 chk("en_resume", 64'(req_ready), 64'b0100);
    tick();
    req_valid = '0;
    chk("en_resume_inf", 64'(inflight), 64'd1);
    tick();
    tick();
    tick();
    chk("en_resume_v", 64'(rsp_valid), 64'b0100);
    chk("en_resume_y", rsp_y, 64'd12);

    // Reset mid-flight: three accepts (3, 0, 1), then reset for one cycle
    req_valid = 4'hF;
    #1 chk("mid_grant3", 64'(req_ready), 64'b1000);
    tick();
    chk("mid_grant0", 64'(req_ready), 64'b0001);
    tick();
    chk("mid_grant1", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    #1 chk("mid_rst_inf", 64'(inflight), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_no_rsp", 64'(rsp_valid), 64'd0);
      chk("mid_no_inf", 64'(inflight),  64'd0);
    end
    req_valid = 4'hF;
    #1 chk("mid_ptr_restart", 64'(req_ready), 64'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
